// File: rtl/uart_frame_tx_pkg.sv
// Shared types and constants for the multi-byte UART frame transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        UTX_IDLE,
        UTX_START,
        UTX_DATA,
        UTX_PARITY,
        UTX_STOP
    } utx_state_e;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    function automatic int unsigned calc_bps_cnt(input int unsigned clk_hz,
                                                 input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_frame_tx_if.sv
// Frame handshake bundle: payload plus valid/ready between frame producer and transmitter.
interface uart_frame_tx_if #(
    parameter int unsigned NBYTES    = 10,
    parameter int unsigned DATA_BITS = 8
);
    logic [NBYTES*DATA_BITS-1:0] frame_data;
    logic                        frame_valid;
    logic                        frame_ready;

    modport master (output frame_data, output frame_valid, input frame_ready);
    modport slave  (input frame_data, input frame_valid, output frame_ready);
endinterface

// File: rtl/uart_frame_tx_baud_tick.sv
// Bit-period counter: counts 0..BPS_CNT-1 while enabled, ticks on the last count.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned BPS_CNT = 10
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic bit_tick_o
);
    localparam int unsigned     CW       = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(BPS_CNT - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            if (cnt_q == CNT_LAST) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bit_tick_o = en_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_frame_tx.sv
// Multi-character UART transmitter: sends NBYTES characters per accepted frame, back-to-back.
module uart_frame_tx
    import uart_pkg::*;
#(
    parameter int unsigned SYS_CLK_FRE = 100_000_000,
    parameter int unsigned BPS         = 9600,
    parameter int unsigned NBYTES      = 10,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY      = PAR_NONE,
    parameter int unsigned STOP_BITS   = 1
) (
    input  logic           sys_clk,
    input  logic           sys_rst_n,
    uart_frame_tx_if.slave frame_if,
    output logic           uart_txd,
    output logic           tx_busy,
    output logic           tx_done
);
    localparam int unsigned   BPS_CNT   = calc_bps_cnt(SYS_CLK_FRE, BPS);
    localparam int unsigned   FW        = NBYTES * DATA_BITS;
    localparam int unsigned   BW        = $clog2(DATA_BITS);
    localparam int unsigned   IW        = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam bit            HAS_PAR   = (PARITY != PAR_NONE);
    localparam logic          PAR_INV   = (PARITY == PAR_ODD);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NBYTES - 1);
    localparam logic          STOP_LAST = (STOP_BITS == 2);

    utx_state_e    state_q;
    logic [FW-1:0] shift_q;
    logic [BW-1:0] bit_cnt_q;
    logic          stop_cnt_q;
    logic [IW-1:0] idx_q;
    logic          par_q;
    logic          txd_q;
    logic          done_q;

    logic          accept;
    logic          baud_en;
    logic          bit_tick;

    assign accept               = (state_q == UTX_IDLE) && frame_if.frame_valid;
    assign baud_en              = (state_q != UTX_IDLE);
    assign frame_if.frame_ready = (state_q == UTX_IDLE);

    uart_baud_tick #(.BPS_CNT(BPS_CNT)) u_baud (
        .clk_i      (sys_clk),
        .rst_ni     (sys_rst_n),
        .clr_i      (accept),
        .en_i       (baud_en),
        .bit_tick_o (bit_tick)
    );

    // The whole payload shifts right one bit per data bit sent, so after
    // DATA_BITS shifts the next character already sits at the bottom.
    // Parity is accumulated as the bits go out.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= UTX_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            idx_q      <= '0;
            par_q      <= 1'b0;
            txd_q      <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                UTX_IDLE: begin
                    txd_q <= 1'b1;
                    if (frame_if.frame_valid) begin
                        shift_q <= frame_if.frame_data;
                        idx_q   <= '0;
                        txd_q   <= 1'b0;
                        state_q <= UTX_START;
                    end
                end
                UTX_START: begin
                    if (bit_tick) begin
                        txd_q     <= shift_q[0];
                        par_q     <= shift_q[0];
                        shift_q   <= shift_q >> 1;
                        bit_cnt_q <= '0;
                        state_q   <= UTX_DATA;
                    end
                end
                UTX_DATA: begin
                    if (bit_tick) begin
                        if (bit_cnt_q == BIT_LAST) begin
                            if (HAS_PAR) begin
                                txd_q   <= par_q ^ PAR_INV;
                                state_q <= UTX_PARITY;
                            end else begin
                                txd_q      <= 1'b1;
                                stop_cnt_q <= 1'b0;
                                state_q    <= UTX_STOP;
                            end
                        end else begin
                            txd_q     <= shift_q[0];
                            par_q     <= par_q ^ shift_q[0];
                            shift_q   <= shift_q >> 1;
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                UTX_PARITY: begin
                    if (bit_tick) begin
                        txd_q      <= 1'b1;
                        stop_cnt_q <= 1'b0;
                        state_q    <= UTX_STOP;
                    end
                end
                UTX_STOP: begin
                    if (bit_tick) begin
                        if (stop_cnt_q == STOP_LAST) begin
                            if (idx_q == IDX_LAST) begin
                                txd_q   <= 1'b1;
                                done_q  <= 1'b1;
                                state_q <= UTX_IDLE;
                            end else begin
                                idx_q   <= idx_q + 1'b1;
                                txd_q   <= 1'b0;
                                state_q <= UTX_START;
                            end
                        end else begin
                            stop_cnt_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    txd_q   <= 1'b1;
                    state_q <= UTX_IDLE;
                end
            endcase
        end
    end

    assign uart_txd = txd_q;
    assign tx_busy  = (state_q != UTX_IDLE);
    assign tx_done  = done_q;

endmodule
